// File: rtl/multicycle_control.sv
// Control FSM for the multicycle RV32I core (lw, sw, R/I-type ALU, beq/bne, jal, lui).
// Sequences fetch/decode/execute/memory/writeback over the shared datapath.
module multicycle_control (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        adr_src,
    output logic        ir_write,
    output logic        pc_write,
    output logic        reg_write,
    output logic [1:0]  result_src,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [3:0]  alu_control,
    output logic [2:0]  imm_src,
    output logic        illegal,
    output logic [3:0]  state
);

    localparam int unsigned STATE_W = 4;
    localparam int unsigned ALU_W   = 4;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_LUI      = 4'd11,
        S_ILLEGAL  = 4'd12,
        S_RESET    = 4'd13
    } state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [ALU_W-1:0] ALU_ADD  = 4'b0000;
    localparam logic [ALU_W-1:0] ALU_SUB  = 4'b0001;
    localparam logic [ALU_W-1:0] ALU_AND  = 4'b0010;
    localparam logic [ALU_W-1:0] ALU_OR   = 4'b0011;
    localparam logic [ALU_W-1:0] ALU_XOR  = 4'b0100;
    localparam logic [ALU_W-1:0] ALU_SLT  = 4'b0101;
    localparam logic [ALU_W-1:0] ALU_SLTU = 4'b0110;
    localparam logic [ALU_W-1:0] ALU_SLL  = 4'b0111;
    localparam logic [ALU_W-1:0] ALU_SRL  = 4'b1000;
    localparam logic [ALU_W-1:0] ALU_SRA  = 4'b1001;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    state_e state_q, state_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_instr_bits;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

    // funct3 -> ALU op; alt selects SUB/SRA variants
    function automatic logic [ALU_W-1:0] alu_op(input logic [2:0] f3, input logic alt);
        logic [ALU_W-1:0] op;
        op = ALU_ADD;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    // Opcode dispatch out of DECODE, with unsupported encodings trapped
    function automatic state_e decode_next(input logic [6:0] op, input logic [2:0] f3,
                                           input logic [6:0] f7);
        state_e nxt;
        nxt = S_ILLEGAL;
        case (op)
            OP_LOAD, OP_STORE: nxt = (f3 == 3'b010) ? S_MEMADR : S_ILLEGAL;
            OP_RTYPE: begin
                if (f7 == 7'b0000000)
                    nxt = S_EXECR;
                else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))
                    nxt = S_EXECR;
                else
                    nxt = S_ILLEGAL;
            end
            OP_ITYPE:  nxt = S_EXECI;
            OP_BRANCH: nxt = (f3 == 3'b000 || f3 == 3'b001) ? S_BRANCH : S_ILLEGAL;
            OP_JAL:    nxt = S_JAL;
            OP_LUI:    nxt = S_LUI;
            default:   nxt = S_ILLEGAL;
        endcase
        return nxt;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-state outputs; FETCH and BRANCH are Mealy on mem_ready/zero
    always_comb begin
        state_d     = state_q;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        adr_src     = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        reg_write   = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_control = ALU_ADD;
        imm_src     = IMM_I;
        illegal     = 1'b0;

        case (state_q)
            S_RESET: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                mem_req = 1'b1;
                adr_src = 1'b0;
                if (mem_ready) begin
                    ir_write    = 1'b1;
                    alu_src_a   = 2'b00;
                    alu_src_b   = 2'b10;
                    alu_control = ALU_ADD;
                    result_src  = 2'b10;
                    pc_write    = 1'b1;
                    state_d     = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_a   = 2'b01;
                alu_src_b   = 2'b01;
                alu_control = ALU_ADD;
                imm_src     = (opcode == OP_JAL) ? IMM_J : IMM_B;
                state_d     = decode_next(opcode, funct3, funct7);
            end
            S_MEMADR: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b01;
                alu_control = ALU_ADD;
                imm_src     = (opcode == OP_STORE) ? IMM_S : IMM_I;
                state_d     = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXECR: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b00;
                alu_control = alu_op(funct3, funct7[5]);
                state_d     = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b01;
                imm_src     = IMM_I;
                alu_control = alu_op(funct3, (funct3 == 3'b101) && funct7[5]);
                state_d     = S_ALUWB;
            end
            S_ALUWB: begin
                result_src = 2'b00;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b00;
                alu_control = ALU_SUB;
                result_src  = 2'b00;
                pc_write    = zero ^ funct3[0];
                state_d     = S_FETCH;
            end
            S_JAL: begin
                alu_src_a   = 2'b01;
                alu_src_b   = 2'b10;
                alu_control = ALU_ADD;
                result_src  = 2'b00;
                pc_write    = 1'b1;
                state_d     = S_ALUWB;
            end
            S_LUI: begin
                alu_src_a   = 2'b11;
                alu_src_b   = 2'b01;
                imm_src     = IMM_U;
                alu_control = ALU_ADD;
                state_d     = S_ALUWB;
            end
            S_ILLEGAL: begin
                illegal = 1'b1;
                state_d = S_ILLEGAL;
            end
            default: begin
                state_d = S_RESET;
            end
        endcase
    end

    assign state = STATE_W'(state_q);

endmodule
